// File: rtl/spi_slave_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_endpoint
// Brief    : Mode-0 SPI slave endpoint. It oversamples the SPI pins on PCLK,
//            takes TX words from a one-word holding register and stores RX
//            words in a first-word-fall-through FIFO.
//            Optional echo of the last received word: SPI_SLAVE_ECHO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_endpoint #(
    parameter int                 DATA_W      = 16,
    parameter int                 FIFO_DEPTH  = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  IDLE_WORD   = '0
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          SCLK,
    input  logic                          SS,
    input  logic                          MOSI,
    output logic                          MISO,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(DATA_W + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // One extra stage on SCLK/SS holds the previous synchronised sample
    logic [SYNC_STAGES:0]   r_sclk_pipe;
    logic [SYNC_STAGES:0]   r_ss_pipe;
    logic [SYNC_STAGES-1:0] r_mosi_pipe;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ss_rise;
    logic                   w_ss_fall;
    logic                   w_ss_lvl;
    logic                   w_mosi;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_CW-1:0]        r_bit_cnt;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_hold;
    logic                   r_hold_full;
    logic [DATA_W-1:0]      w_load_word;
    logic [DATA_W-1:0]      w_fill_word;
    logic                   w_load;
    logic                   w_push;
    logic                   w_frame_abort;
    logic                   w_tx_accept;

    logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_AW:0]          r_count;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push_ok;
    logic                   r_frame_err;
    logic                   r_overrun;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_sclk_pipe <= '0;
            r_ss_pipe   <= '1;
            r_mosi_pipe <= '0;
        end else begin
            r_sclk_pipe[0] <= SCLK;
            r_ss_pipe[0]   <= SS;
            r_mosi_pipe[0] <= MOSI;
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                r_sclk_pipe[i] <= r_sclk_pipe[i-1];
                r_ss_pipe[i]   <= r_ss_pipe[i-1];
            end
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_mosi_pipe[i] <= r_mosi_pipe[i-1];
            end
        end
    end

    assign w_sclk_rise = r_sclk_pipe[SYNC_STAGES-1] & ~r_sclk_pipe[SYNC_STAGES];
    assign w_sclk_fall = ~r_sclk_pipe[SYNC_STAGES-1] & r_sclk_pipe[SYNC_STAGES];
    assign w_ss_rise   = r_ss_pipe[SYNC_STAGES-1] & ~r_ss_pipe[SYNC_STAGES];
    assign w_ss_fall   = ~r_ss_pipe[SYNC_STAGES-1] & r_ss_pipe[SYNC_STAGES];
    assign w_ss_lvl    = r_ss_pipe[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_pipe[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_push        = 1'b0;
        w_frame_abort = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = c_ST_SHIFT;
                    w_load      = 1'b1;
                end
            end
            c_ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_frame_abort = (r_bit_cnt != '0) && (r_bit_cnt < c_CW'(DATA_W));
                end else if (w_sclk_rise && (r_bit_cnt == c_CW'(DATA_W - 1))) begin
                    w_state_nxt = c_ST_DONE;
                end else if (w_sclk_fall && (r_bit_cnt == '0)) begin
                    // First falling edge of a back-to-back frame
                    w_load = 1'b1;
                end
            end
            c_ST_DONE: begin
                w_push      = 1'b1;
                w_state_nxt = w_ss_lvl ? c_ST_IDLE : c_ST_SHIFT;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_tx_accept = tx_valid & ~r_hold_full;
    assign w_load_word = r_hold_full ? r_hold : (tx_valid ? tx_data : w_fill_word);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if ((r_state == c_ST_SHIFT) && !w_ss_rise && w_sclk_rise) begin
                r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + c_CW'(1);
            end else if (r_state != c_ST_SHIFT) begin
                r_bit_cnt <= '0;
            end

            if (w_load) begin
                r_tx_shift <= w_load_word;
            end else if ((r_state == c_ST_SHIFT) && w_sclk_fall && (r_bit_cnt != '0) &&
                         (r_bit_cnt < c_CW'(DATA_W))) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end

            // A word offered in the load cycle goes straight to the shifter
            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_tx_accept && !w_load) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_ECHO_EN
    logic [DATA_W-1:0] r_echo;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_echo <= IDLE_WORD;
        end else if (w_push) begin
            r_echo <= r_rx_shift;
        end
    end

    assign w_fill_word = r_echo;
`else
    assign w_fill_word = IDLE_WORD;
`endif

    assign w_pop     = (r_count != '0) & rx_ready;
    assign w_full    = (r_count == (c_AW+1)'(FIFO_DEPTH));
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_rx_shift;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_frame_err <= w_frame_abort;
            r_overrun   <= w_push & w_full & ~w_pop;
        end
    end

    assign MISO      = (r_state != c_ST_IDLE) & r_tx_shift[DATA_W-1];
    assign busy      = (r_state != c_ST_IDLE);
    assign tx_ready  = ~r_hold_full;
    assign rx_valid  = (r_count != '0);
    assign rx_data   = rx_valid ? r_mem[r_rd_ptr] : '0;
    assign rx_count  = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_endpoint.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_slave_endpoint
// Brief    : Directed self-checking bench for spi_slave_endpoint with a
//            scoreboard of expected MISO and RX FIFO words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_endpoint;
    localparam int          DATA_W      = 16;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] IDLE_WORD   = 16'h0000;

    logic        PCLK     = 1'b0;
    logic        PRESET   = 1'b1;
    logic        SCLK     = 1'b0;
    logic        SS       = 1'b1;
    logic        MOSI     = 1'b0;
    logic        MISO;
    logic [15:0] tx_data  = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [2:0]  rx_count;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int          total  = 0;
    int          bad    = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          ov_exp = 0;
    int          fe0;
    int          ov0;
    logic [15:0] miso_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] last_rx = IDLE_WORD;
    logic [15:0] got;

    spi_slave_endpoint #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_WORD   (IDLE_WORD)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .SCLK      (SCLK),
        .SS        (SS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    function automatic logic [15:0] fill_word();
`ifdef SPI_SLAVE_ECHO_EN
        return last_rx;
`else
        return IDLE_WORD;
`endif
    endfunction

    task automatic hold_load(input logic [15:0] w);
        check("tx_ready_before_load", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before rise
    task automatic shift_bits(input logic [15:0] w, input int nbits, input int inj_bit,
                              input logic [15:0] inj_w, output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[15-i];
            if (i == inj_bit) begin
                tx_data  = inj_w;
                tx_valid = 1'b1;
                cyc(1);
                tx_valid = 1'b0;
                cyc(7);
            end else begin
                cyc(8);
            end
            cap[15-i] = MISO;
            SCLK = 1'b1;
            cyc(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] w, input logic [15:0] exp_miso, input string tag,
                        input bit raise, input int inj_bit, input logic [15:0] inj_w);
        logic [15:0] cap;
        miso_q.push_back(exp_miso);
        if (rx_q.size() < FIFO_DEPTH) rx_q.push_back(w);
        else                          ov_exp++;
        SS = 1'b0;
        shift_bits(w, 16, inj_bit, inj_w, cap);
        cyc(8);
        check({tag, "_miso"}, {16'd0, cap}, {16'd0, miso_q.pop_front()});
        last_rx = w;
        if (raise) begin
            SS = 1'b1;
            cyc(8);
        end
    endtask

    task automatic pop_all(input string tag);
        while (rx_q.size() > 0) begin
            check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd1);
            check({tag, "_rx_data"}, {16'd0, rx_data}, {16'd0, rx_q.pop_front()});
            rx_ready = 1'b1;
            cyc(1);
            rx_ready = 1'b0;
        end
        check({tag, "_drained"}, {29'd0, rx_count}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_miso"},      {31'd0, MISO},      32'd0);
        check({tag, "_tx_ready"},  {31'd0, tx_ready},  32'd1);
        check({tag, "_rx_valid"},  {31'd0, rx_valid},  32'd0);
        check({tag, "_rx_data"},   {16'd0, rx_data},   32'd0);
        check({tag, "_rx_count"},  {29'd0, rx_count},  32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"},   {31'd0, overrun},   32'd0);
    endtask

    initial begin
        cyc(3);
        check_reset_vals("rst");
        PRESET = 1'b0;
        cyc(4);

        // Preloaded TX word, single frame
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        hold_load(16'hAAAB);
        check("t1_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        send(16'hFAA2, 16'hAAAB, "t1", 1'b1, -1, '0);
        check("t1_rx_count", {29'd0, rx_count}, 32'd1);
        check("t1_tx_ready_empty", {31'd0, tx_ready}, 32'd1);
        pop_all("t1");
        check("t1_frame_err_cnt", fe_cnt, fe0);
        check("t1_overrun_cnt", ov_cnt, ov0);

        // Empty holding register: idle word (or echo)
        send(16'h1234, fill_word(), "t2a", 1'b1, -1, '0);
        pop_all("t2a");
        send(16'h5678, fill_word(), "t2b", 1'b1, -1, '0);
        pop_all("t2b");

        // Back-to-back frames, holding register refilled during frame 1
        send(16'h0001, fill_word(), "t3a", 1'b0, 4, 16'hBEEF);
        check("t3_busy_between", {31'd0, busy}, 32'd1);
        send(16'h0002, 16'hBEEF, "t3b", 1'b1, -1, '0);
        check("t3_rx_count", {29'd0, rx_count}, 32'd2);
        check("t3_tx_ready", {31'd0, tx_ready}, 32'd1);
        pop_all("t3");

        // FIFO overflow: five frames, no pops
        ov0    = ov_cnt;
        ov_exp = 0;
        for (int k = 0; k < 5; k++) begin
            send(16'h0010 + 16'(k), fill_word(), "t4", 1'b1, -1, '0);
        end
        check("t4_rx_count_full", {29'd0, rx_count}, 32'd4);
        check("t4_overrun_pulses", ov_cnt - ov0, ov_exp);
        check("t4_overrun_one", ov_cnt - ov0, 32'd1);
        pop_all("t4");

        // SS raised after 7 bits
        fe0 = fe_cnt;
        SS  = 1'b0;
        shift_bits(16'hFFFF, 7, -1, '0, got);
        cyc(8);
        check("t5_busy_mid", {31'd0, busy}, 32'd1);
        SS = 1'b1;
        cyc(8);
        check("t5_frame_err_one", fe_cnt - fe0, 32'd1);
        check("t5_rx_count", {29'd0, rx_count}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_miso", {31'd0, MISO}, 32'd0);

        // Reset during bit 9
        send(16'h0BAD, fill_word(), "t6pre", 1'b1, -1, '0);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        SS  = 1'b0;
        shift_bits(16'hC3C3, 9, 2, 16'h7777, got);
        check("t6_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        check("t6_rx_count_pre", {29'd0, rx_count}, 32'd1);
        MOSI = 1'b1;
        cyc(3);
        PRESET = 1'b1;
        cyc(1);
        check_reset_vals("t6_rst");
        SS = 1'b1;
        cyc(2);
        PRESET = 1'b0;
        cyc(8);
        rx_q.delete();
        last_rx = IDLE_WORD;
        send(16'hC3C3, fill_word(), "t6", 1'b1, -1, '0);
        pop_all("t6");
        check("t6_frame_err_cnt", fe_cnt, fe0);
        check("t6_overrun_cnt", ov_cnt, ov0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
